// File: rtl/matadd_pkg.sv
// Shared definitions for the streaming matrix add/sub block: operation
// encodings, controller states and the lane arithmetic helpers.
package matadd_pkg;

    localparam logic [1:0] MODE_ADD_WRAP = 2'b00;
    localparam logic [1:0] MODE_SUB_WRAP = 2'b01;
    localparam logic [1:0] MODE_ADD_SAT  = 2'b10;
    localparam logic [1:0] MODE_SUB_SAT  = 2'b11;

    // Lanes are evaluated in a fixed-width signed domain wide enough to hold
    // the exact sum/difference of two elements of up to 64 bits.
    localparam int OP_W = 65;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_DIVIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Accumulator never overflows: at most 2^(2*dim_w) elements of data_w bits.
    function automatic int acc_width(input int data_w, input int dim_w);
        return data_w + 2 * dim_w;
    endfunction

    function automatic logic mode_is_sub(input logic [1:0] m);
        return (m == MODE_SUB_WRAP) || (m == MODE_SUB_SAT);
    endfunction

    function automatic logic mode_is_sat(input logic [1:0] m);
        return (m == MODE_ADD_SAT) || (m == MODE_SUB_SAT);
    endfunction

    // Reduce an exact result to a w-bit signed value, either by wrapping
    // (sign-extend the low w bits) or by clamping to the w-bit signed range.
    function automatic logic signed [OP_W-1:0] sat_wrap(
        input logic signed [OP_W-1:0] r,
        input logic                   sat,
        input int                     w
    );
        logic signed [OP_W-1:0] one;
        logic signed [OP_W-1:0] hi;
        logic signed [OP_W-1:0] lo;
        logic signed [OP_W-1:0] res;
        one = {{(OP_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (w - 1)) - one;
        lo  = ~hi;
        if (!sat) begin
            res = (r <<< (OP_W - w)) >>> (OP_W - w);
        end else if (r > hi) begin
            res = hi;
        end else if (r < lo) begin
            res = lo;
        end else begin
            res = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/matadd_div.sv
// Sequential signed restoring divider: signed dividend by unsigned nonzero
// divisor, one quotient bit per cycle over ACC_W cycles, quotient truncated
// toward zero and narrowed to Q_W bits. done pulses with the final bit.
module matadd_div
    import matadd_pkg::*;
#(
    parameter int ACC_W = 64,
    parameter int DEN_W = 32,
    parameter int Q_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CW = $clog2(ACC_W + 1);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [ACC_W-1:0] quo_q, quo_d;

    // Load magnitude on start, then shift one dividend bit into the partial
    // remainder per cycle; the down-counter's terminal count ends the run.
    always_comb begin
        logic [DEN_W:0] rem_shift;
        logic           qbit;
        busy_d    = busy_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        den_d     = den_q;
        quo_d     = quo_q;
        rem_shift = {rem_q, quo_q[ACC_W-1]};
        qbit      = 1'b0;
        if (start) begin
            busy_d = 1'b1;
            neg_d  = dividend[ACC_W-1];
            quo_d  = dividend[ACC_W-1] ? -dividend : dividend;
            rem_d  = '0;
            den_d  = divisor;
            cnt_d  = CW'(ACC_W);
        end else if (busy_q) begin
            if (rem_shift >= {1'b0, den_q}) begin
                rem_d = DEN_W'(rem_shift - {1'b0, den_q});
                qbit  = 1'b1;
            end else begin
                rem_d = rem_shift[DEN_W-1:0];
            end
            quo_d = {quo_q[ACC_W-2:0], qbit};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            quo_q  <= quo_d;
        end
    end

    assign done     = done_q;
    assign quotient = Q_W'(neg_q ? -quo_q : quo_q);

endmodule

// File: rtl/matadd_stream.sv
// Streaming element-wise matrix add/sub with result sum and mean.
//
// state  | meaning
// IDLE   | waiting for start; latches mode and size
// RUN    | joining A/B beats into the output register
// DRAIN  | all beats consumed, waiting for the output register to empty
// DIVIDE | dividing the accumulated sum by the element count
// DONE   | one-cycle done pulse, sum/mean valid
module matadd_stream
    import matadd_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  LANES  = 4,
    parameter int  DIM_W  = 16,
    localparam int ACC_W  = acc_width(DATA_W, DIM_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [DIM_W-1:0]        rows,
    input  logic [DIM_W-1:0]        cols,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [LANES*DATA_W-1:0] a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [LANES*DATA_W-1:0] b_data,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [LANES*DATA_W-1:0] y_data,
    output logic [LANES-1:0]        y_keep,
    output logic                    y_last,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        sum,
    output logic [DATA_W-1:0]       mean
);

    localparam int NW = 2 * DIM_W;
    localparam int LW = $clog2(LANES + 1);
    localparam int DW = LANES * DATA_W;

    state_t                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [NW-1:0]            n_q, n_d;
    logic [NW-1:0]            beats_left_q, beats_left_d;
    logic [LW-1:0]            rem_q, rem_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0]        mean_q, mean_d;
    logic                     y_valid_q, y_valid_d;
    logic                     y_last_q, y_last_d;
    logic [DW-1:0]            y_data_q, y_data_d;
    logic [LANES-1:0]         y_keep_q, y_keep_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [NW-1:0]            n_calc;
    logic [NW-1:0]            beats_calc;
    logic [LW-1:0]            rem_calc;
    logic                     slot_free;
    logic                     can_take;
    logic                     fire;
    logic                     last_beat;
    logic [DW-1:0]            lane_data;
    logic [LANES-1:0]         lane_keep;
    logic signed [ACC_W-1:0]  beat_sum;
    logic                     div_start;
    logic                     div_done;
    logic [DATA_W-1:0]        div_quot;

    assign n_calc     = NW'(rows) * NW'(cols);
    assign rem_calc   = LW'(n_calc % NW'(LANES));
    assign beats_calc = n_calc / NW'(LANES) + NW'(rem_calc != '0);

    // A beat is joined only when both operands are present and the output
    // register can take the result in the same cycle.
    assign slot_free = !y_valid_q || y_ready;
    assign can_take  = (state_q == S_RUN) && (beats_left_q != '0) && slot_free;
    assign a_ready   = can_take && b_valid;
    assign b_ready   = can_take && a_valid;
    assign fire      = can_take && a_valid && b_valid;
    assign last_beat = (beats_left_q == NW'(1));

    // Per-lane add/sub with wrap or clamp; tail lanes of the final beat are
    // zeroed and left out of the beat sum.
    always_comb begin
        logic signed [OP_W-1:0] a_x;
        logic signed [OP_W-1:0] b_x;
        logic signed [OP_W-1:0] r_x;
        logic [DATA_W-1:0]      lane_val;
        lane_data = '0;
        lane_keep = '0;
        beat_sum  = '0;
        for (int i = 0; i < LANES; i++) begin
            a_x      = OP_W'($signed(a_data[i*DATA_W +: DATA_W]));
            b_x      = OP_W'($signed(b_data[i*DATA_W +: DATA_W]));
            r_x      = mode_is_sub(mode_q) ? (a_x - b_x) : (a_x + b_x);
            lane_val = DATA_W'(sat_wrap(r_x, mode_is_sat(mode_q), DATA_W));
            lane_keep[i] = !(last_beat && (rem_q != '0) && (LW'(i) >= rem_q));
            if (lane_keep[i]) begin
                lane_data[i*DATA_W +: DATA_W] = lane_val;
                beat_sum = beat_sum + ACC_W'($signed(lane_val));
            end
        end
    end

    // Controller next-state, accumulator and output-register update.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        n_d          = n_q;
        beats_left_d = beats_left_q;
        rem_d        = rem_q;
        acc_d        = acc_q;
        sum_d        = sum_q;
        mean_d       = mean_q;
        y_valid_d    = y_valid_q;
        y_last_d     = y_last_q;
        y_data_d     = y_data_q;
        y_keep_d     = y_keep_q;
        done_d       = 1'b0;
        div_start    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    n_d          = n_calc;
                    beats_left_d = beats_calc;
                    rem_d        = rem_calc;
                    acc_d        = '0;
                    if (n_calc == '0) begin
                        sum_d   = '0;
                        mean_d  = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (fire) begin
                    acc_d        = acc_q + beat_sum;
                    beats_left_d = beats_left_q - NW'(1);
                    if (last_beat) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!y_valid_q) begin
                    div_start = 1'b1;
                    state_d   = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (div_done) begin
                    sum_d   = acc_q;
                    mean_d  = div_quot;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fire) begin
            y_valid_d = 1'b1;
            y_data_d  = lane_data;
            y_keep_d  = lane_keep;
            y_last_d  = last_beat;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // All controller and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            n_q          <= '0;
            beats_left_q <= '0;
            rem_q        <= '0;
            acc_q        <= '0;
            sum_q        <= '0;
            mean_q       <= '0;
            y_valid_q    <= 1'b0;
            y_last_q     <= 1'b0;
            y_data_q     <= '0;
            y_keep_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            n_q          <= n_d;
            beats_left_q <= beats_left_d;
            rem_q        <= rem_d;
            acc_q        <= acc_d;
            sum_q        <= sum_d;
            mean_q       <= mean_d;
            y_valid_q    <= y_valid_d;
            y_last_q     <= y_last_d;
            y_data_q     <= y_data_d;
            y_keep_q     <= y_keep_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    matadd_div #(
        .ACC_W (ACC_W),
        .DEN_W (NW),
        .Q_W   (DATA_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (acc_q),
        .divisor  (n_q),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_keep  = y_keep_q;
    assign y_last  = y_last_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sum     = sum_q;
    assign mean    = mean_q;

endmodule

// File: tb/tb_matadd_stream.sv
// Directed bench for matadd_stream with default parameters.
module tb_matadd_stream;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int DIM_W  = 16;
    localparam int ACC_W  = 64;
    localparam int DW     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        mode;
    logic [DIM_W-1:0]  rows, cols;
    logic              a_valid, a_ready, b_valid, b_ready;
    logic [DW-1:0]     a_data, b_data;
    logic              y_valid, y_ready;
    logic [DW-1:0]     y_data;
    logic [LANES-1:0]  y_keep;
    logic              y_last, busy, done;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] mean;

    matadd_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rows(rows), .cols(cols),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_keep(y_keep),
        .y_last(y_last), .busy(busy), .done(done), .sum(sum), .mean(mean)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] a_mem [0:255];
    logic [DATA_W-1:0] b_mem [0:255];
    logic [DW-1:0]     y_q[$];
    logic [LANES-1:0]  k_q[$];
    logic              l_q[$];
    logic [ACC_W-1:0]  sum_got;
    logic [DATA_W-1:0] mean_got;
    int                done_cyc;
    bit                ready_seen;
    int                stall_err;

    task automatic drive_beat(input int idx, input int n);
        for (int l = 0; l < LANES; l++) begin
            int e;
            e = idx * LANES + l;
            if (e < n) begin
                a_data[l*DATA_W +: DATA_W] = a_mem[e];
                b_data[l*DATA_W +: DATA_W] = b_mem[e];
            end else begin
                a_data[l*DATA_W +: DATA_W] = 32'h1234_5678;
                b_data[l*DATA_W +: DATA_W] = 32'h0BAD_F00D;
            end
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 6; i++) begin
            a_mem[i] = 32'(i + 1);
            b_mem[i] = 32'd2;
        end
    endtask

    // Runs one job from start to done, collecting output beats and sum/mean.
    task automatic run_job(input int r, input int c, input logic [1:0] m, input bit bp);
        int n, nb, idx, cyc;
        bit fire, hold, got;
        logic [DW-1:0] hd;
        logic [LANES-1:0] hk;
        logic hl;
        n = r * c;
        nb = (n + LANES - 1) / LANES;
        y_q.delete(); k_q.delete(); l_q.delete();
        ready_seen = 0; stall_err = 0; done_cyc = -1;
        hd = '0; hk = '0; hl = 1'b0;
        rows = DIM_W'(r); cols = DIM_W'(c); mode = m;
        a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0; got = 0; hold = 0;
        while (!got && cyc < 3000) begin
            a_valid = (idx < nb) && (!bp || $urandom_range(0, 3) != 0);
            b_valid = (idx < nb) && (!bp || $urandom_range(0, 3) != 0);
            y_ready = !bp || $urandom_range(0, 2) != 0;
            drive_beat(idx, n);
            #1;
            if (a_ready || b_ready) ready_seen = 1;
            fire = a_valid && a_ready && b_valid && b_ready;
            if (y_valid && y_ready) begin
                y_q.push_back(y_data); k_q.push_back(y_keep); l_q.push_back(y_last);
            end
            if (done) begin
                got = 1; sum_got = sum; mean_got = mean; done_cyc = cyc;
            end
            hold = y_valid && !y_ready;
            if (hold) begin
                hd = y_data; hk = y_keep; hl = y_last;
            end
            @(posedge clk); #1;
            if (fire) idx++;
            if (hold && (y_valid !== 1'b1 || y_data !== hd || y_keep !== hk || y_last !== hl))
                stall_err++;
            cyc++;
        end
        a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL job_done rows=%0d cols=%0d: done not seen after %0d cycles, required done=1", r, c, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 2'b00; rows = '0; cols = '0;
        a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1; a_data = '1; b_data = '1;
        #12;
        checks++;
        if ({a_ready, b_ready, y_valid, y_last, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000000", {a_ready, b_ready, y_valid, y_last, busy, done});
        end
        checks++;
        if (y_data !== '0 || y_keep !== '0) begin
            errors++;
            $display("FAIL reset_y got data=%h keep=%b required 0", y_data, y_keep);
        end
        checks++;
        if (sum !== '0 || mean !== '0) begin
            errors++;
            $display("FAIL reset_sum got sum=%h mean=%h required 0", sum, mean);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        load_basic();
        run_job(2, 3, 2'b00, 0);
        checks++;
        if (y_q.size() != 2 || y_q[0] !== {32'd6, 32'd5, 32'd4, 32'd3} || y_q[1] !== {32'd0, 32'd0, 32'd8, 32'd7}) begin
            errors++;
            $display("FAIL basic_data got %0d beats, first=%h required 2 beats 6_5_4_3 / 0_0_8_7", y_q.size(), (y_q.size() > 0) ? y_q[0] : '0);
        end
        checks++;
        if (k_q.size() != 2 || k_q[0] !== 4'b1111 || k_q[1] !== 4'b0011) begin
            errors++;
            $display("FAIL basic_keep got %0d beats required keep 1111 then 0011", k_q.size());
        end
        checks++;
        if (l_q.size() != 2 || l_q[0] !== 1'b0 || l_q[1] !== 1'b1) begin
            errors++;
            $display("FAIL basic_last got %0d beats required last 0 then 1", l_q.size());
        end
        checks++;
        if (sum_got !== 64'd33 || mean_got !== 32'd5) begin
            errors++;
            $display("FAIL basic_sum got sum=%0d mean=%0d required 33 and 5", sum_got, mean_got);
        end
    endtask

    task automatic test_sat();
        logic [1:0]        m_t [4]  = '{2'b11, 2'b10, 2'b00, 2'b01};
        logic [DATA_W-1:0] a_t [4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [DATA_W-1:0] y_t [4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [ACC_W-1:0]  s_t [4]  = '{64'hFFFF_FFFF_8000_0000, 64'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h7FFF_FFFF};
        for (int t = 0; t < 4; t++) begin
            a_mem[0] = a_t[t];
            b_mem[0] = 32'd1;
            run_job(1, 1, m_t[t], 0);
            checks++;
            if (y_q.size() != 1 || y_q[0] !== {96'd0, y_t[t]} || k_q[0] !== 4'b0001) begin
                errors++;
                $display("FAIL sat_lane mode=%b got %0d beats y=%h required y=%h keep=0001", m_t[t], y_q.size(), (y_q.size() > 0) ? y_q[0] : '0, y_t[t]);
            end
            checks++;
            if (sum_got !== s_t[t] || mean_got !== y_t[t]) begin
                errors++;
                $display("FAIL sat_sum mode=%b got sum=%h mean=%h required %h %h", m_t[t], sum_got, mean_got, s_t[t], y_t[t]);
            end
        end
    endtask

    task automatic test_negative();
        a_mem[0] = 32'hFFFF_FFF9; a_mem[1] = 32'd0;
        b_mem[0] = 32'd0;         b_mem[1] = 32'd0;
        run_job(1, 2, 2'b00, 0);
        checks++;
        if (y_q.size() != 1 || y_q[0] !== {64'd0, 32'd0, 32'hFFFF_FFF9} || k_q[0] !== 4'b0011 || l_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL neg_beat got %0d beats required one beat -7,0 keep 0011 last", y_q.size());
        end
        checks++;
        if (sum_got !== 64'hFFFF_FFFF_FFFF_FFF9 || mean_got !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL neg_sum got sum=%h mean=%h required -7 and -3", sum_got, mean_got);
        end
    endtask

    task automatic test_zero();
        run_job(0, 5, 2'b00, 0);
        checks++;
        if (ready_seen || y_q.size() != 0) begin
            errors++;
            $display("FAIL zero_ready got ready_seen=%0d beats=%0d required 0 0", ready_seen, y_q.size());
        end
        checks++;
        if (done_cyc < 0 || done_cyc > 1) begin
            errors++;
            $display("FAIL zero_latency got done at loop cycle %0d required 0..1", done_cyc);
        end
        checks++;
        if (sum_got !== '0 || mean_got !== '0) begin
            errors++;
            $display("FAIL zero_sum got sum=%h mean=%h required 0 0", sum_got, mean_got);
        end
    endtask

    task automatic test_backpressure();
        longint s;
        int bad_data, bad_ctl;
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = 32'(i * 7);
            b_mem[i] = 32'hFFFF_FF00 + 32'(i);
        end
        run_job(16, 16, 2'b00, 1);
        s = 0; bad_data = 0; bad_ctl = 0;
        for (int i = 0; i < 256; i++) s += longint'($signed(32'(i * 8 - 256)));
        checks++;
        if (y_q.size() != 64) begin
            errors++;
            $display("FAIL bp_count got %0d beats required 64", y_q.size());
        end else begin
            for (int j = 0; j < 64; j++) begin
                for (int l = 0; l < LANES; l++)
                    if (y_q[j][l*DATA_W +: DATA_W] !== 32'((j * 4 + l) * 8 - 256)) bad_data++;
                if (k_q[j] !== 4'b1111 || l_q[j] !== (j == 63)) bad_ctl++;
            end
        end
        checks++;
        if (bad_data != 0 || bad_ctl != 0) begin
            errors++;
            $display("FAIL bp_beats got %0d bad lanes %0d bad keep/last required 0 0", bad_data, bad_ctl);
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL bp_stable got %0d unstable stalls required 0", stall_err);
        end
        checks++;
        if (sum_got !== 64'(s) || mean_got !== 32'(s / 256)) begin
            errors++;
            $display("FAIL bp_sum got sum=%0d mean=%0d required %0d %0d", sum_got, mean_got, s, s / 256);
        end
    endtask

    task automatic test_reset_mid_run();
        load_basic();
        rows = 16'd4; cols = 16'd4; mode = 2'b00; start = 1'b1; y_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        drive_beat(0, 16);
        @(posedge clk); #1;
        drive_beat(1, 16);
        start = 1'b1; rows = '0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (a_ready !== 1'b1 || done !== 1'b0 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run got a_ready=%b done=%b y_valid=%b required 1 0 1", a_ready, done, y_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, b_ready, y_valid, y_last, busy, done} !== 6'b0 || y_data !== '0 || y_keep !== '0) begin
            errors++;
            $display("FAIL midrst_ctrl got ctl=%b data=%h keep=%b required all 0", {a_ready, b_ready, y_valid, y_last, busy, done}, y_data, y_keep);
        end
        checks++;
        if (sum !== '0 || mean !== '0) begin
            errors++;
            $display("FAIL midrst_sum got sum=%h mean=%h required 0 0", sum, mean);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(2, 3, 2'b00, 0);
        checks++;
        if (y_q.size() != 2 || sum_got !== 64'd33 || mean_got !== 32'd5) begin
            errors++;
            $display("FAIL midrst_rerun got beats=%0d sum=%0d mean=%0d required 2 33 5", y_q.size(), sum_got, mean_got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_negative();
        test_zero();
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
